// File: rtl/sysid_ctrl_pkg.sv
// Shared definitions for the system ID boot checker.
//   state_t              : controller state encoding
//   DEFAULT_EXPECTED_ID  : expected word 0 (regenerated per build)
//   DEFAULT_EXPECTED_TS  : expected word 1 (regenerated per build)
//   ADDR_ID / ADDR_TS    : word addresses inside the sysid slave
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd1240784590;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1327442508;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Stall counter for one Avalon read.
//   clk, reset : clock and synchronous active-high reset
//   i_clr      : clear the count (dominates i_en)
//   i_en       : count one stalled cycle
//   o_tc       : count has reached TIMEOUT_CYCLES-1
module sysid_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VALUE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TC_VALUE)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/sysid_checker.sv
// Boot-time checker for the 2-word system ID slave.
// Reads word 0 (system ID) and word 1 (build timestamp) over Avalon-MM,
// compares them with the build-time constants and reports a sticky verdict.
//   clk, reset                    : clock, synchronous active-high reset
//   start                         : run a check (honoured in IDLE/DONE only)
//   avm_address, avm_read         : Avalon-MM read master request
//   avm_readdata, avm_waitrequest : Avalon-MM slave response
//   busy, done                    : check in progress / verdict valid
//   pass, id_mismatch, ts_mismatch, timeout : verdict flags
//   sys_id, sys_ts                : last captured words
//   retry_count                   : retries consumed by current/last check
module sysid_checker
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] sys_id,
  output logic [31:0] sys_ts,
  output logic [2:0]  retry_count
);

  state_t r_state;
  state_t w_next;

  logic        r_drop;      // read strobe withdrawn for one cycle after a timeout
  logic        r_auto_go;   // one-shot start on the first cycle out of reset
  logic        r_pass;
  logic        r_id_mm;
  logic        r_ts_mm;
  logic        r_timeout;
  logic [31:0] r_sys_id;
  logic [31:0] r_sys_ts;
  logic [2:0]  r_retry;

  logic w_rd_state;
  logic w_accept;
  logic w_stall;
  logic w_tc;
  logic w_to_hit;
  logic w_start;
  logic w_retry_ok;

  assign w_rd_state = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  // Accept is tested before the threshold, so a grant on the last allowed
  // stall cycle still completes the read.
  assign w_accept   = w_rd_state && !r_drop && !avm_waitrequest;
  assign w_stall    = w_rd_state && !r_drop && avm_waitrequest;
  assign w_to_hit   = w_stall && w_tc;
  assign w_start    = ((r_state == S_IDLE) && (start || r_auto_go)) ||
                      ((r_state == S_DONE) && start);
  assign w_retry_ok = (r_retry < 3'(MAX_RETRIES));

  // Counter clears whenever the read is not stalling; within one read state
  // that is equivalent to clearing on accept or state change.
  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (!w_stall || w_to_hit),
    .i_en  (w_stall),
    .o_tc  (w_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_next = S_RD_ID;
      end
      S_RD_ID: begin
        if (r_drop)        w_next = w_retry_ok ? S_RD_ID : S_DONE;
        else if (w_accept) w_next = S_RD_TS;
      end
      S_RD_TS: begin
        if (r_drop)        w_next = w_retry_ok ? S_RD_ID : S_DONE;
        else if (w_accept) w_next = S_CHECK;
      end
      S_CHECK: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    case (r_state)
      S_RD_ID: begin
        busy     = 1'b1;
        avm_read = !r_drop;
      end
      S_RD_TS: begin
        busy        = 1'b1;
        avm_read    = !r_drop;
        avm_address = ADDR_TS;
      end
      S_CHECK: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Captured words, verdict flags and retry bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop    <= 1'b0;
      r_auto_go <= AUTO_START;
      r_pass    <= 1'b0;
      r_id_mm   <= 1'b0;
      r_ts_mm   <= 1'b0;
      r_timeout <= 1'b0;
      r_sys_id  <= '0;
      r_sys_ts  <= '0;
      r_retry   <= '0;
    end else begin
      r_auto_go <= 1'b0;
      r_drop    <= w_to_hit;

      if (w_start) begin
        r_pass    <= 1'b0;
        r_id_mm   <= 1'b0;
        r_ts_mm   <= 1'b0;
        r_timeout <= 1'b0;
        r_retry   <= '0;
      end

      if (w_accept && (r_state == S_RD_ID)) r_sys_id <= avm_readdata;
      if (w_accept && (r_state == S_RD_TS)) r_sys_ts <= avm_readdata;

      if (r_state == S_CHECK) begin
        r_id_mm <= (r_sys_id != EXPECTED_ID);
        r_ts_mm <= (r_sys_ts != EXPECTED_TS);
        r_pass  <= (r_sys_id == EXPECTED_ID) && (r_sys_ts == EXPECTED_TS);
      end

      if (r_drop) begin
        if (w_retry_ok) begin
          r_retry <= r_retry + 3'd1;
        end else begin
          r_timeout <= 1'b1;
          r_pass    <= 1'b0;
        end
      end
    end
  end

  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign timeout     = r_timeout;
  assign sys_id      = r_sys_id;
  assign sys_ts      = r_sys_ts;
  assign retry_count = r_retry;

endmodule
